// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and PC increment.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset and increment enable.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = (count == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: boot delay, normal fetch, stalls, branch redirect with
// wrong-path flush, and HALT/resume. Outputs are a Mealy decode of state and inputs.
module fetch_sequencer
  import if_pkg::*;
#(
  parameter int PC_WIDTH    = 6,
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_req,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic [PC_WIDTH-1:0]  jmp_address,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic [PC_WIDTH-1:0]  PCout,
  output logic [PC_WIDTH-1:0]  PCin,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_flush,
  output logic                 fetch_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam int BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;

  fetch_state_t      state_reg, state_next;
  logic [BOOT_W-1:0] boot_cnt_reg, boot_cnt_next;
  logic              taken;
  logic              boot_done;
  logic [PC_WIDTH-1:0] pc_inc;

  assign taken     = Branch && Zero;
  assign pc_inc    = PCout + PC_WIDTH'(PC_STEP);
  // With BOOT_CYCLES=0 the FSM still spends exactly one cycle in BOOT.
  assign boot_done = (BOOT_CYCLES == 0) || (boot_cnt_reg == BOOT_W'(BOOT_LAST));

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    PCin          = pc_inc;
    pc_we         = 1'b0;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    fetch_valid   = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      ifid_flush = 1'b1;
    end else begin
      unique case (state_reg)
        BOOT: begin
          ifid_flush    = 1'b1;
          boot_cnt_next = boot_cnt_reg + BOOT_W'(1);
          if (boot_done) begin
            state_next    = RUN;
            boot_cnt_next = '0;
          end
        end
        RUN: begin
          if (taken) begin
            PCin       = jmp_address;
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_next = FLUSH;
          end else if (halt_req) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_next = HALT;
          end else if (!stall_req) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            fetch_valid = 1'b1;
          end
        end
        FLUSH: begin
          // A taken branch here belongs to the already-squashed slot, so it is ignored.
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          if (!stall_req) begin
            pc_we      = 1'b1;
            state_next = RUN;
          end
        end
        HALT: begin
          halted = 1'b1;
          if (resume) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_fetch_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_valid),
    .count (fetch_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus reset, boot and saturation sequences.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       stall_req;
  logic       Branch;
  logic       Zero;
  logic [5:0] jmp_address;
  logic       halt_req;
  logic       resume;
  logic [5:0] PCout;

  logic [5:0]  PCin;
  logic        pc_we, ifid_we, ifid_flush, fetch_valid, halted;
  logic [15:0] fetch_count;

  logic [5:0]  PCin2;
  logic        pc_we2, ifid_we2, ifid_flush2, fetch_valid2, halted2;
  logic [1:0]  fetch_count2;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.PC_WIDTH(6), .BOOT_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .Branch(Branch), .Zero(Zero),
    .jmp_address(jmp_address), .halt_req(halt_req), .resume(resume), .PCout(PCout),
    .PCin(PCin), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .fetch_valid(fetch_valid), .halted(halted), .fetch_count(fetch_count)
  );

  // Second instance: no boot delay and a 2-bit counter to reach saturation quickly.
  fetch_sequencer #(.PC_WIDTH(6), .BOOT_CYCLES(0), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .stall_req(stall_req), .Branch(Branch), .Zero(Zero),
    .jmp_address(jmp_address), .halt_req(halt_req), .resume(resume), .PCout(PCout),
    .PCin(PCin2), .pc_we(pc_we2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2),
    .fetch_valid(fetch_valid2), .halted(halted2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall, br, zero;
    logic [5:0]  jmp;
    logic        hreq, res;
    logic [5:0]  pcout;
    logic [5:0]  e_pcin;
    logic        e_pcwe, e_ifidwe, e_flush, e_fv, e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int stall, input int br, input int zero,
                     input int jmp, input int hreq, input int res, input int pcout,
                     input int e_pcin, input int e_pcwe, input int e_ifidwe, input int e_flush,
                     input int e_fv, input int e_halted, input int e_cnt);
    vec_t v;
    v.name = name;       v.stall = 1'(stall);  v.br = 1'(br);       v.zero = 1'(zero);
    v.jmp = 6'(jmp);     v.hreq = 1'(hreq);    v.res = 1'(res);     v.pcout = 6'(pcout);
    v.e_pcin = 6'(e_pcin);   v.e_pcwe = 1'(e_pcwe); v.e_ifidwe = 1'(e_ifidwe);
    v.e_flush = 1'(e_flush); v.e_fv = 1'(e_fv);     v.e_halted = 1'(e_halted);
    v.e_cnt = 16'(e_cnt);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    rst = 1'b0; stall_req = 0; Branch = 0; Zero = 0; jmp_address = 0;
    halt_req = 0; resume = 0; PCout = 0;

    //   name          st br z  jmp h  r  pco  pcin we iwe fl fv ht cnt
    add("boot0",        0, 0, 0, 0,  0, 0, 0,   4,   0, 0,  1, 0, 0, 0);
    add("boot1",        0, 1, 1, 20, 1, 0, 0,   4,   0, 0,  1, 0, 0, 0);
    add("boot2",        1, 0, 0, 0,  0, 0, 0,   4,   0, 0,  1, 0, 0, 0);
    add("boot3",        0, 0, 0, 0,  0, 0, 0,   4,   0, 0,  1, 0, 0, 0);
    add("run_pc0",      0, 0, 0, 0,  0, 0, 0,   4,   1, 1,  0, 1, 0, 0);
    add("run_pc4",      0, 0, 0, 0,  0, 0, 4,   8,   1, 1,  0, 1, 0, 1);
    add("run_pc8",      0, 0, 0, 0,  0, 0, 8,   12,  1, 1,  0, 1, 0, 2);
    add("br_not_taken", 0, 1, 0, 40, 0, 0, 12,  16,  1, 1,  0, 1, 0, 3);
    add("taken_w_stall",1, 1, 1, 40, 0, 0, 16,  40,  1, 1,  1, 0, 0, 4);
    add("flush_ign_br", 0, 1, 1, 20, 0, 0, 40,  44,  1, 1,  1, 0, 0, 4);
    add("stall1",       1, 0, 0, 0,  0, 0, 44,  48,  0, 0,  0, 0, 0, 4);
    add("stall2",       1, 0, 0, 0,  0, 0, 44,  48,  0, 0,  0, 0, 0, 4);
    add("stall3",       1, 0, 0, 0,  0, 0, 44,  48,  0, 0,  0, 0, 0, 4);
    add("stall_done",   0, 0, 0, 0,  0, 0, 44,  48,  1, 1,  0, 1, 0, 4);
    add("run_pc48",     0, 0, 0, 0,  0, 0, 48,  52,  1, 1,  0, 1, 0, 5);
    add("taken_to8",    0, 1, 1, 8,  0, 0, 52,  8,   1, 1,  1, 0, 0, 6);
    add("flush_stall",  1, 0, 0, 0,  0, 0, 8,   12,  0, 1,  1, 0, 0, 6);
    add("flush_end",    0, 0, 0, 0,  0, 0, 8,   12,  1, 1,  1, 0, 0, 6);
    add("halt_req",     0, 0, 0, 0,  1, 0, 12,  16,  0, 1,  1, 0, 0, 6);
    add("halt_ign",     1, 1, 1, 30, 1, 0, 12,  16,  0, 0,  0, 0, 1, 6);
    add("halt_resume",  0, 0, 0, 0,  1, 1, 12,  16,  0, 0,  0, 0, 1, 6);
    add("resumed_pc12", 0, 0, 0, 0,  0, 0, 12,  16,  1, 1,  0, 1, 0, 6);
    add("wrap_pc60",    0, 0, 0, 0,  0, 0, 60,  0,   1, 1,  0, 1, 0, 7);
    add("run_pc0b",     0, 0, 0, 0,  0, 0, 0,   4,   1, 1,  0, 1, 0, 8);
    add("taken_to60",   0, 1, 1, 60, 0, 0, 4,   60,  1, 1,  1, 0, 0, 9);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, pc_we, ifid_we, ifid_flush, fetch_valid, halted, 1'b0},
          {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_count", {16'd0, fetch_count}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      stall_req = vecs[i].stall; Branch = vecs[i].br; Zero = vecs[i].zero;
      jmp_address = vecs[i].jmp; halt_req = vecs[i].hreq; resume = vecs[i].res;
      PCout = vecs[i].pcout;
      @(negedge clk);
      check(vecs[i].name,
            {5'd0, PCin, pc_we, ifid_we, ifid_flush, fetch_valid, halted, fetch_count},
            {5'd0, vecs[i].e_pcin, vecs[i].e_pcwe, vecs[i].e_ifidwe, vecs[i].e_flush,
             vecs[i].e_fv, vecs[i].e_halted, vecs[i].e_cnt});
      @(posedge clk);
      #1;
    end

    // Now in FLUSH: assert reset asynchronously mid-cycle.
    stall_req = 0; Branch = 0; Zero = 0; jmp_address = 0; halt_req = 0; resume = 0;
    PCout = 60;
    #2;
    rst = 1'b0;
    #1;
    check("midflush_rst_ctrl", {27'd0, pc_we, ifid_we, ifid_flush, fetch_valid, halted},
          {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("midflush_rst_cnt", {16'd0, fetch_count}, 32'd0);
    check("midflush_rst_small", {29'd0, ifid_flush2, fetch_count2}, {29'd0, 1'b1, 2'd0});
    @(posedge clk);
    @(posedge clk);
    #1;
    PCout = 0;
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      logic [15:0] exp_cnt;
      logic [1:0]  exp_cnt2;
      @(negedge clk);
      exp_cnt = (k >= 4) ? 16'(k - 4) : 16'd0;
      if (k < 4)
        check($sformatf("reboot_big_c%0d", k),
              {13'd0, pc_we, ifid_flush, fetch_valid, fetch_count},
              {13'd0, 1'b0, 1'b1, 1'b0, exp_cnt});
      else
        check($sformatf("reboot_big_c%0d", k),
              {13'd0, pc_we, ifid_flush, fetch_valid, fetch_count},
              {13'd0, 1'b1, 1'b0, 1'b1, exp_cnt});
      exp_cnt2 = (k == 0) ? 2'd0 : ((k - 1 > 3) ? 2'd3 : 2'(k - 1));
      if (k == 0)
        check("small_boot0", {27'd0, pc_we2, ifid_flush2, fetch_valid2, fetch_count2},
              {27'd0, 1'b0, 1'b1, 1'b0, 2'd0});
      else
        check($sformatf("small_sat_c%0d", k),
              {27'd0, pc_we2, ifid_flush2, fetch_valid2, fetch_count2},
              {27'd0, 1'b1, 1'b0, 1'b1, exp_cnt2});
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the instruction-fetch stage. Drives the PC register's next value and write-enable, and the IF/ID pipeline register's write-enable and flush. It sequences boot, normal fetch, hazard stalls, taken-branch redirects with wrong-path flushing, and HALT/resume. A saturating fetch counter provides performance observation.

## Interface
- PC_WIDTH, 6, width of PC and branch target
- BOOT_CYCLES, 4, idle cycles after reset release before the first fetch (0 allowed)
- CNT_WIDTH, 16, width of fetch counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall_req  in  1  hazard unit requests fetch freeze
- Branch  in  1  resolved branch instruction present
- Zero  in  1  ALU zero flag; taken = Branch && Zero
- jmp_address  in  PC_WIDTH  branch target
- halt_req  in  1  HALT decoded in ID
- resume  in  1  leave HALT
- PCout  in  PC_WIDTH  current PC register value
- PCin  out  PC_WIDTH  next PC value
- pc_we  out  1  PC register write-enable
- ifid_we  out  1  IF/ID register write-enable
- ifid_flush  out  1  IF/ID register clears to NOP
- fetch_valid  out  1  the instruction fetched this cycle is architecturally valid
- halted  out  1  FSM in HALT
- fetch_count  out  CNT_WIDTH  valid fetches since reset, saturating

## Operation
- States: BOOT, RUN, FLUSH, HALT. Outputs are a Mealy decode of state and inputs. state, boot counter and fetch_count are registered.
- Reset (rst=0): state=BOOT, boot counter=0, fetch_count=0.
  - Outputs while in reset: pc_we=0, ifid_we=0, ifid_flush=1, fetch_valid=0, halted=0.
- PCin default is PCout+4 modulo 2^PC_WIDTH, so wrap-around is silent. PCin=jmp_address only when taken is accepted.
- BOOT:
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=1.
  - Counter increments each cycle. The FSM moves to RUN on the edge where counter==BOOT_CYCLES-1, or after the first cycle if BOOT_CYCLES=0.
  - All requests are ignored.
- RUN, evaluated in fixed priority:
  1. taken: pc_we=1, PCin=jmp_address, ifid_we=1, ifid_flush=1, fetch_valid=0; next state FLUSH.
  2. halt_req: pc_we=0, ifid_we=1, ifid_flush=1; next state HALT.
  3. stall_req: pc_we=0, ifid_we=0, ifid_flush=0, fetch_valid=0; stay in RUN.
  4. otherwise: pc_we=1, ifid_we=1, ifid_flush=0, fetch_valid=1; fetch_count+1, saturating at all-ones.
- FLUSH: lasts one cycle and squashes the second wrong-path slot.
  - Outputs: pc_we=1, PCin=PCout+4, ifid_we=1, ifid_flush=1, fetch_valid=0.
  - Next state RUN.
  - stall_req in FLUSH: hold the PC (pc_we=0) and stay in FLUSH.
  - taken in FLUSH is ignored, because the branch is already squashed.
- HALT:
  - Outputs: halted=1, pc_we=0, ifid_we=0, ifid_flush=0, fetch_valid=0.
  - resume=1 → RUN on the next edge. Fetching restarts at the held PC.
  - Branch, stall_req and halt_req are ignored.
- Simultaneous resume and halt_req in HALT: resume wins.

## Timing
- Redirect has zero latency: PCin and pc_we are valid in the same cycle that taken is sampled. The target is fetched at edge+1.
- Branch penalty is 2 bubbles (RUN-taken cycle + FLUSH cycle).
- fetch_count updates on the edge that closes a valid-fetch cycle.
- First valid fetch happens BOOT_CYCLES cycles after rst deasserts; the PC is still at reset value 0.
- Reset asserted mid-operation: all registered state clears asynchronously, and outputs take their reset values immediately.

## Structure
- Shared package `if_pkg`:
  - state enum, 2 bits: BOOT=0, RUN=1, FLUSH=2, HALT=3
  - constant PC_STEP=4
- One sub-module, `sat_counter`: parameterised width, active-low async reset, increment enable, saturating. Instantiated for fetch_count. The boot counter is inline.

## Test plan
- Reset release with BOOT_CYCLES=4, no requests → 4 cycles of pc_we=0 and ifid_flush=1, then PCin=4,8,12; fetch_count=3 after 3 RUN cycles.
- In RUN at PCout=8, assert Branch=1, Zero=1, jmp_address=40 → same cycle PCin=40 with ifid_flush=1; next cycle is FLUSH with ifid_flush=1; fetch_count does not advance in either cycle.
- Branch=1 with Zero=0 → normal PCout+4, no flush. stall_req and taken together → redirect wins.
- stall_req held 3 cycles → pc_we=0, ifid_we=0 for exactly 3 cycles, then fetch resumes at the held PC. A stall during FLUSH extends FLUSH.
- halt_req → halted=1 next cycle; a taken branch during HALT is ignored; resume → RUN with PCin=PCout+4.
- Set PC_WIDTH=6 with PCout=60 → PCin=0 (wrap). Preload fetch_count to 16'hFFFF → it stays 16'hFFFF. Pulse rst=0 mid-FLUSH → state BOOT and all outputs at reset values.
